imager_rx_mlane: RTL
====================

# imager_rx_mlane

Multi-lane successor to the single-pixel sensor receiver. It captures NUM_LANES pixels per clki beat from a parallel image sensor and applies an optional per-frame crop window. It flags frames whose rows have inconsistent lengths. The output is a lane-packed dvo/dtypeo/datao stream of `DTYPE_* words that feeds the image-processing pipeline ahead of packers and header inserters; this block emits no header.

## Interface
- PIXEL_WIDTH, 12, bits per sensor pixel.
- DATA_WIDTH, 16, bits per output lane; must be ≥ PIXEL_WIDTH.
- NUM_LANES, 2, pixels per beat; must be a power of two, 1..8.
- DIM_WIDTH, 16, width of row and column counters and crop fields.

- clki  in  1  pixel clock.
- resetb_clki  in  1  reset; asynchronous, active-low.
- enable  in  1  stream enable; asynchronous to clki, synchronised internally.
- fv, lv, dvi  in  1 each  frame valid, line valid, data valid, straight from the pads.
- datai  in  NUM_LANES*PIXEL_WIDTH  pixels; lane 0 in the LSBs holds the lowest column.
- left_justify  in  1  0 = zero-pad each lane in its MSBs; 1 = place the pixel in the lane MSBs and zero-pad below.
- test_pat  in  1  replace sensor data with the test pattern.
- crop_en  in  1  enable the crop window.
- crop_row_start, crop_rows, crop_col_start, crop_cols  in  DIM_WIDTH each  crop window; column fields have their low log2(NUM_LANES) bits ignored.
- num_rows, num_cols  out  DIM_WIDTH each  uncropped dimensions of the last frame, in pixels.
- frame_count  out  16  count of frames started.
- row_len_err  out  1  last completed frame had unequal row lengths.
- dvo  out  1  output word valid.
- dtypeo  out  `DTYPE_WIDTH  output word type.
- datao  out  NUM_LANES*DATA_WIDTH  output data.

## Operation
- **Input capture.**
  - fv, lv, dvi and datai are registered twice (_s, _ss); an IOB attribute applies to the first stage.
  - enable is registered once.
  - Edges: fv_rise = fv_s & !fv_ss; fv_fall and lv_rise/lv_fall are defined the same way.
  - A beat is fv_ss & lv_ss & dvi_ss.
- **State machine.**
  - WAIT: entered at reset, or from any state whenever enable_s = 0. dvo = 0.
  - WAIT → IDLE when enable_s = 1 and fv_s, fv_ss and the third fv stage are all 0.
  - IDLE → FRAME on fv_rise.
  - FRAME → IDLE on the cycle that emits FRAME_END.
  - Result: a frame that is already in progress when the block is enabled is discarded whole.
- **Output priority** (one word per cycle; otherwise dvo = 0, datao = 0, dtypeo = 0):
  1. beat → `DTYPE_PIXEL.
  2. fv_rise → `DTYPE_FRAME_START, with the pre-increment frame_count in lane 0.
  3. fv_fall delayed one cycle → `DTYPE_FRAME_END, data 0.
  4. lv_rise → `DTYPE_ROW_START, with the cropped row index in lane 0.
  5. lv_fall delayed one cycle → `DTYPE_ROW_END, data 0.
  - On control words, lanes 1..NUM_LANES-1 are 0.
- **Counters.**
  - row_cnt clears on fv_rise and increments on lv_fall.
  - col_cnt clears on lv_rise and increments by NUM_LANES per beat.
  - Both wrap modulo 2^DIM_WIDTH.
  - frame_count increments on fv_rise and wraps 0xFFFF → 0.
  - num_rows and num_cols latch row_cnt and col_cnt on fv_fall.
- **Crop.**
  - The crop fields are sampled into shadow registers on fv_rise and held for the whole frame.
  - Row r is inside the window when crop_row_start ≤ r < crop_row_start + crop_rows; the sum is computed at DIM_WIDTH+1 bits, so it never wraps.
  - A beat with first column c is inside the window when crop_col_start ≤ c < crop_col_start + crop_cols.
  - With crop_en = 0, everything is inside the window.
  - Pixels, ROW_START and ROW_END are emitted only for rows and beats inside the window. FRAME_START and FRAME_END are always emitted.
  - The ROW_START index is r - crop_row_start.
- **Test pattern.** Lane i = (row_cnt + col_cnt + i) truncated to PIXEL_WIDTH, using uncropped coordinates. It is muxed in ahead of the _ss stage.
- **Row-length check.**
  - The length of the first row of a frame is stored.
  - Any later row whose col_cnt at lv_fall differs from it sets a per-frame sticky bit.
  - row_len_err takes the sticky bit's value at FRAME_END; the sticky bit clears on fv_rise.
  - This check uses uncropped columns.

## Timing
- Reset values: every output is 0; state = WAIT.
- Latency, counted from the clki edge that first samples the input:
  - fv high → FRAME_START at the 2nd following edge.
  - lv high → ROW_START at the 2nd following edge.
  - Beat data → PIXEL at the 3rd following edge (one-stage mux-to-format pipeline).
  - fv or lv low → FRAME_END or ROW_END at the 3rd following edge.
- Simultaneous events:
  - fv and lv rising together: ROW_START is suppressed; FRAME_START only.
  - fv and lv falling together: ROW_END is suppressed; FRAME_END only.
  - A beat on the same cycle as a lower-priority event: that event's word is lost. It is never queued.
- enable dropping mid-frame: dvo = 0 from the 2nd edge after the drop, with no FRAME_END. Output restarts at the next full frame.
- Asynchronous reset mid-frame: the block returns to WAIT.
- There is no backpressure; downstream must accept one word per cycle.

## Test plan
- NUM_LANES = 2, 4 rows × 8 cols, test_pat = 1, no crop → FRAME_START(0); 4 × [ROW_START(r), 4 PIXEL beats with lanes {r+c, r+c+1}, ROW_END]; FRAME_END; num_rows = 4, num_cols = 8, frame_count = 1.
- Crop rows 1..2, cols 2..5 on an 8 × 8 frame → 2 rows, each with ROW_START(0/1) and 2 beats whose first columns are 2 and 4; FRAME_START and FRAME_END still present.
- enable raised while fv = 1 → nothing emitted until after fv falls; the next frame is complete; FRAME_START carries frame_count counting every frame seen since reset.
- fv and lv rise together and fall together → no ROW_START on row 0 and no ROW_END on the last row; all pixels are present.
- Rows of 8, 8, 6 columns → row_len_err = 1 after FRAME_END; the next uniform frame clears it to 0.
- left_justify = 1, PIXEL_WIDTH = 12, pixel 0xABC → lane = 0xABC0; with left_justify = 0 → 0x0ABC.

Source files
------------

// File: rtl/imager_rx_mlane.sv
// imager_rx_mlane: multi-lane parallel sensor receiver with per-frame crop window and row-length check
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 3
`define DTYPE_FRAME_START 3'd1
`define DTYPE_FRAME_END 3'd2
`define DTYPE_ROW_START 3'd3
`define DTYPE_ROW_END 3'd4
`define DTYPE_PIXEL 3'd5
`endif

module imager_rx_mlane #(
  parameter int PIXEL_WIDTH = 12,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_LANES = 2,
  parameter int DIM_WIDTH = 16
) (
  input  logic clki,
  input  logic resetb_clki,
  input  logic enable,
  input  logic fv,
  input  logic lv,
  input  logic dvi,
  input  logic [NUM_LANES*PIXEL_WIDTH-1:0] datai,
  input  logic left_justify,
  input  logic test_pat,
  input  logic crop_en,
  input  logic [DIM_WIDTH-1:0] crop_row_start,
  input  logic [DIM_WIDTH-1:0] crop_rows,
  input  logic [DIM_WIDTH-1:0] crop_col_start,
  input  logic [DIM_WIDTH-1:0] crop_cols,
  output logic [DIM_WIDTH-1:0] num_rows,
  output logic [DIM_WIDTH-1:0] num_cols,
  output logic [15:0] frame_count,
  output logic row_len_err,
  output logic dvo,
  output logic [`DTYPE_WIDTH-1:0] dtypeo,
  output logic [NUM_LANES*DATA_WIDTH-1:0] datao
);
  localparam int LW = NUM_LANES * PIXEL_WIDTH;
  localparam int CW = DIM_WIDTH > 16 ? DIM_WIDTH : 16;
  localparam logic [DIM_WIDTH-1:0] STEP = DIM_WIDTH'(NUM_LANES);
  localparam logic [DIM_WIDTH-1:0] COL_MASK = ~DIM_WIDTH'(NUM_LANES - 1);
  typedef enum logic [1:0] {S_WAIT, S_IDLE, S_FRAME} state_t;
  state_t r_state, w_state_nxt;
  (* IOB = "TRUE" *) logic r_fv_s, r_lv_s, r_dvi_s;
  (* IOB = "TRUE" *) logic [LW-1:0] r_data_s;
  logic r_fv_ss, r_lv_ss, r_dvi_ss, r_fv_sss, r_en_s;
  logic [LW-1:0] r_data_ss, w_pat;
  logic [DIM_WIDTH-1:0] r_row_cnt, r_col_cnt, r_num_rows, r_num_cols;
  logic [15:0] r_frame_cnt;
  logic r_crop_en, r_fe_d, r_re_d, r_first_seen, r_len_sticky, r_row_len_err;
  logic [DIM_WIDTH-1:0] r_crs, r_crr, r_ccs, r_ccc, r_first_len;
  logic [`DTYPE_WIDTH-1:0] r_a_typ, w_typ, r_dtype;
  logic [LW-1:0] r_a_pix;
  logic [CW-1:0] r_a_ctl, w_ctl;
  logic r_dvo;
  logic [NUM_LANES*DATA_WIDTH-1:0] r_datao, w_datao;
  logic w_fv_rise, w_fv_fall, w_lv_rise, w_lv_fall, w_beat, w_row_in, w_col_in;
  logic w_frm, w_pix, w_fs, w_fe, w_rs, w_re;
  logic [DIM_WIDTH-1:0] w_col_inc, w_col_nxt, w_row_nxt, w_row_idx;
  logic [DIM_WIDTH:0] w_row_end, w_col_end;

  assign w_fv_rise = r_fv_s & ~r_fv_ss;
  assign w_fv_fall = ~r_fv_s & r_fv_ss;
  assign w_lv_rise = r_lv_s & ~r_lv_ss;
  assign w_lv_fall = ~r_lv_s & r_lv_ss;
  assign w_beat = r_fv_ss & r_lv_ss & r_dvi_ss;
  assign w_col_inc = r_col_cnt + (w_beat ? STEP : '0);
  assign w_col_nxt = w_lv_rise ? '0 : w_col_inc;
  assign w_row_nxt = w_fv_rise ? '0 : r_row_cnt + DIM_WIDTH'(w_lv_fall);
  assign w_row_end = {1'b0, r_crs} + {1'b0, r_crr};
  assign w_col_end = {1'b0, r_ccs} + {1'b0, r_ccc};
  assign w_row_in = ~r_crop_en | (r_row_cnt >= r_crs && {1'b0, r_row_cnt} < w_row_end);
  assign w_col_in = ~r_crop_en | (r_col_cnt >= r_ccs && {1'b0, r_col_cnt} < w_col_end);
  assign w_row_idx = r_crop_en ? r_row_cnt - r_crs : r_row_cnt;
  assign w_frm = r_en_s & (r_state == S_FRAME);
  assign w_pix = w_frm & w_beat & w_row_in & w_col_in;
  assign w_fs = r_en_s & (r_state == S_IDLE) & w_fv_rise;
  assign w_fe = w_frm & r_fe_d;
  assign w_rs = w_frm & w_lv_rise & w_row_in;
  assign w_re = w_frm & r_re_d;

  // test pattern uses the coordinates the beat will have once it reaches the _ss stage
  always_comb begin
    w_pat = '0;
    for (int i = 0; i < NUM_LANES; i++)
      w_pat[i*PIXEL_WIDTH +: PIXEL_WIDTH] = PIXEL_WIDTH'(w_row_nxt + w_col_nxt + DIM_WIDTH'(i));
  end

  // pad synchronisers; the pattern replaces sensor data ahead of the second stage
  always_ff @(posedge clki or negedge resetb_clki) begin
    if (!resetb_clki) begin
      {r_fv_s, r_lv_s, r_dvi_s, r_fv_ss, r_lv_ss, r_dvi_ss, r_fv_sss, r_en_s} <= '0;
      r_data_s <= '0;
      r_data_ss <= '0;
    end else begin
      {r_fv_s, r_lv_s, r_dvi_s} <= {fv, lv, dvi};
      {r_fv_ss, r_lv_ss, r_dvi_ss, r_fv_sss} <= {r_fv_s, r_lv_s, r_dvi_s, r_fv_ss};
      r_en_s <= enable;
      r_data_s <= datai;
      r_data_ss <= test_pat ? w_pat : r_data_s;
    end
  end

  // one word per cycle by fixed priority; lower-priority events in the same cycle are dropped
  always_comb begin
    w_typ = w_pix ? `DTYPE_PIXEL : w_fs ? `DTYPE_FRAME_START : w_fe ? `DTYPE_FRAME_END :
            w_rs ? `DTYPE_ROW_START : w_re ? `DTYPE_ROW_END : '0;
    w_ctl = w_pix ? '0 : w_fs ? CW'(r_frame_cnt) : (!w_fe && w_rs) ? CW'(w_row_idx) : '0;
    w_state_nxt = !r_en_s ? S_WAIT :
                  (r_state == S_WAIT && !(r_fv_s | r_fv_ss | r_fv_sss)) ? S_IDLE :
                  (r_state == S_IDLE && w_fv_rise) ? S_FRAME :
                  (r_state == S_FRAME && w_typ == `DTYPE_FRAME_END) ? S_IDLE : r_state;
  end

  // state register
  always_ff @(posedge clki or negedge resetb_clki) begin
    if (!resetb_clki) r_state <= S_WAIT;
    else r_state <= w_state_nxt;
  end

  // counters, crop shadows, delayed falls and row-length tracking
  always_ff @(posedge clki or negedge resetb_clki) begin
    if (!resetb_clki) begin
      {r_row_cnt, r_col_cnt, r_num_rows, r_num_cols, r_first_len} <= '0;
      {r_crs, r_crr, r_ccs, r_ccc} <= '0;
      r_frame_cnt <= '0;
      {r_crop_en, r_fe_d, r_re_d, r_first_seen, r_len_sticky, r_row_len_err} <= '0;
    end else begin
      r_row_cnt <= w_row_nxt;
      r_col_cnt <= w_col_nxt;
      r_frame_cnt <= r_frame_cnt + 16'(w_fv_rise);
      r_fe_d <= w_fv_fall;
      r_re_d <= w_lv_fall & w_row_in;
      if (w_fv_fall) begin
        r_num_rows <= w_row_nxt;
        r_num_cols <= w_col_inc;
      end
      if (w_fv_rise) begin
        r_crop_en <= crop_en;
        r_crs <= crop_row_start;
        r_crr <= crop_rows;
        r_ccs <= crop_col_start & COL_MASK;
        r_ccc <= crop_cols & COL_MASK;
        r_first_seen <= 1'b0;
        r_len_sticky <= 1'b0;
      end else if (w_lv_fall) begin
        r_first_seen <= 1'b1;
        if (!r_first_seen) r_first_len <= w_col_inc;
        else if (w_col_inc != r_first_len) r_len_sticky <= 1'b1;
      end
      if (w_typ == `DTYPE_FRAME_END) r_row_len_err <= r_len_sticky;
    end
  end

  // lane formatting of the selected word
  always_comb begin
    w_datao = '0;
    w_datao[DATA_WIDTH-1:0] = DATA_WIDTH'(r_a_ctl);
    for (int i = 0; i < NUM_LANES; i++)
      if (r_a_typ == `DTYPE_PIXEL)
        w_datao[i*DATA_WIDTH +: DATA_WIDTH] = left_justify ?
          DATA_WIDTH'(r_a_pix[i*PIXEL_WIDTH +: PIXEL_WIDTH]) << (DATA_WIDTH - PIXEL_WIDTH) :
          DATA_WIDTH'(r_a_pix[i*PIXEL_WIDTH +: PIXEL_WIDTH]);
  end

  // select stage then format/output stage
  always_ff @(posedge clki or negedge resetb_clki) begin
    if (!resetb_clki) begin
      r_a_typ <= '0;
      r_a_pix <= '0;
      r_a_ctl <= '0;
      r_dvo <= 1'b0;
      r_dtype <= '0;
      r_datao <= '0;
    end else begin
      r_a_typ <= w_typ;
      r_a_pix <= w_pix ? r_data_ss : '0;
      r_a_ctl <= w_ctl;
      r_dvo <= r_a_typ != '0;
      r_dtype <= r_a_typ;
      r_datao <= w_datao;
    end
  end

  assign num_rows = r_num_rows;
  assign num_cols = r_num_cols;
  assign frame_count = r_frame_cnt;
  assign row_len_err = r_row_len_err;
  assign dvo = r_dvo;
  assign dtypeo = r_dtype;
  assign datao = r_datao;
endmodule
